// File: rtl/scarv_soc_dbg_bridge_if.sv
// Byte-stream host link plus memif requestor signals of the debug bridge.
// The bridge uses the master view; the host/UART and memif responder use the slave view.
interface scarv_soc_dbg_bridge_if #(
    parameter int unsigned AW = 32
);
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          mem_req;
    logic          mem_gnt;
    logic          mem_wen;
    logic [3:0]    mem_strb;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_recv;
    logic          mem_ack;
    logic          mem_error;
    logic [31:0]   mem_rdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_gnt, mem_recv, mem_error, mem_rdata,
        output rx_ready, tx_valid, tx_data, mem_req, mem_wen, mem_strb, mem_addr,
               mem_wdata, mem_ack
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_gnt, mem_recv, mem_error, mem_rdata,
        input  rx_ready, tx_valid, tx_data, mem_req, mem_wen, mem_strb, mem_addr,
               mem_wdata, mem_ack
    );
endinterface

// File: rtl/scarv_soc_dbg_bridge.sv
// Debug bridge: decodes host READ/WRITE byte commands into single memif
// transactions and streams the status/read data back to the host.
module scarv_soc_dbg_bridge #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic                        g_clk,
    input  logic                        g_reset,
    scarv_soc_dbg_bridge_if.master      bus
);

    localparam int unsigned BW = 8;

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, REQ, RSP, TX_STAT, TX_DATA, TX_BAD
    } state_t;

    state_t        state, state_d;
    logic [1:0]    cnt, cnt_d;
    logic          is_write, is_write_d;
    logic [31:0]   addr, addr_d;
    logic [31:0]   wdata, wdata_d;
    logic [31:0]   rdata, rdata_d;
    logic          err, err_d;

    logic          rx_ready_d, tx_valid_d, mem_req_d, mem_wen_d, mem_ack_d;
    logic [BW-1:0] tx_data_d;
    logic [3:0]    mem_strb_d;
    logic [AW-1:0] mem_addr_d;
    logic [31:0]   mem_wdata_d;

    logic rx_fire_c, tx_fire_c;

    assign rx_fire_c = bus.rx_valid && bus.rx_ready;
    assign tx_fire_c = bus.tx_valid && bus.tx_ready;

    // State and registered outputs; every output is a function of the next state.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state         <= IDLE;
            cnt           <= 2'd0;
            is_write      <= 1'b0;
            addr          <= 32'd0;
            wdata         <= 32'd0;
            rdata         <= 32'd0;
            err           <= 1'b0;
            bus.rx_ready  <= 1'b0;
            bus.tx_valid  <= 1'b0;
            bus.tx_data   <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_wen   <= 1'b0;
            bus.mem_strb  <= 4'd0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
            bus.mem_ack   <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            is_write      <= is_write_d;
            addr          <= addr_d;
            wdata         <= wdata_d;
            rdata         <= rdata_d;
            err           <= err_d;
            bus.rx_ready  <= rx_ready_d;
            bus.tx_valid  <= tx_valid_d;
            bus.tx_data   <= tx_data_d;
            bus.mem_req   <= mem_req_d;
            bus.mem_wen   <= mem_wen_d;
            bus.mem_strb  <= mem_strb_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_wdata <= mem_wdata_d;
            bus.mem_ack   <= mem_ack_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        is_write_d = is_write;
        addr_d     = addr;
        wdata_d    = wdata;
        rdata_d    = rdata;
        err_d      = err;

        case (state)
            IDLE: if (rx_fire_c) begin
                cnt_d = 2'd0;
                if (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) begin
                    is_write_d = (bus.rx_data == 8'h02);
                    state_d    = ADDR;
                end else begin
                    state_d    = TX_BAD;
                end
            end
            // Multi-byte fields arrive LSB first, so shift in from the top.
            ADDR: if (rx_fire_c) begin
                addr_d = {bus.rx_data, addr[31:8]};
                cnt_d  = 2'(cnt + 2'd1);
                if (cnt == 2'd3) state_d = is_write ? WDATA : REQ;
            end
            WDATA: if (rx_fire_c) begin
                wdata_d = {bus.rx_data, wdata[31:8]};
                cnt_d   = 2'(cnt + 2'd1);
                if (cnt == 2'd3) state_d = REQ;
            end
            REQ: if (bus.mem_req && bus.mem_gnt) state_d = RSP;
            RSP: if (bus.mem_recv && bus.mem_ack) begin
                rdata_d = bus.mem_rdata;
                err_d   = bus.mem_error;
                state_d = TX_STAT;
            end
            TX_STAT: if (tx_fire_c) begin
                cnt_d   = 2'd0;
                state_d = is_write ? IDLE : TX_DATA;
            end
            TX_DATA: if (tx_fire_c) begin
                cnt_d = 2'(cnt + 2'd1);
                if (cnt == 2'd3) state_d = IDLE;
            end
            TX_BAD: if (tx_fire_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rx_ready_d  = (state_d == IDLE) || (state_d == ADDR) || (state_d == WDATA);
        mem_req_d   = (state_d == REQ);
        mem_wen_d   = (state_d == REQ) && is_write_d;
        mem_strb_d  = ((state_d == REQ) && is_write_d) ? 4'b1111 : 4'b0000;
        mem_addr_d  = AW'({addr_d[31:2], 2'b00});
        mem_wdata_d = wdata_d;
        mem_ack_d   = (state_d == RSP);
        tx_valid_d  = (state_d == TX_STAT) || (state_d == TX_DATA) || (state_d == TX_BAD);

        case (state_d)
            TX_STAT: tx_data_d = {7'd0, err_d};
            TX_DATA: tx_data_d = BW'(rdata_d >> {cnt_d, 3'b000});
            TX_BAD:  tx_data_d = 8'hEE;
            default: tx_data_d = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_scarv_soc_dbg_bridge.sv
// Directed bench for the debug bridge: drives host bytes, plays the memif
// responder and checks memif fields and reply bytes against hand-computed values.
module tb_scarv_soc_dbg_bridge;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   grants = 0;
    logic [7:0] rep [8];
    int   nrep;

    always #5 clk = ~clk;

    scarv_soc_dbg_bridge_if #(.AW(32)) bus ();

    scarv_soc_dbg_bridge #(.AW(32), .DW(32)) dut (
        .g_clk   (clk),
        .g_reset (rst),
        .bus     (bus)
    );

    always @(posedge clk) if (bus.mem_req && bus.mem_gnt) grants <= grants + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs();
        check("rst_rx_ready",  32'(bus.rx_ready), 0);
        check("rst_tx_valid",  32'(bus.tx_valid), 0);
        check("rst_tx_data",   32'(bus.tx_data), 0);
        check("rst_mem_req",   32'(bus.mem_req), 0);
        check("rst_mem_wen",   32'(bus.mem_wen), 0);
        check("rst_mem_strb",  32'(bus.mem_strb), 0);
        check("rst_mem_addr",  bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_ack",   32'(bus.mem_ack), 0);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (!bus.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rx_timeout", 32'(n), 0);
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic send_n(input logic [7:0] b [9], input int n);
        for (int i = 0; i < n; i++) send(b[i]);
    endtask

    // Memif responder: expects mem_req one cycle after the last command byte.
    task automatic mem_serve(input int dly, input logic [31:0] rd, input logic er,
                             input logic [31:0] eaddr, input logic ewen, input logic [3:0] estrb,
                             input logic [31:0] ewdata, input bit chk_wdata, input bit poke_rx);
        int n;
        @(negedge clk);
        check("req_latency", 32'(bus.mem_req), 1);
        n = 0;
        while (!bus.mem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (poke_rx) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h55;
        end
        for (int i = 0; i <= dly; i++) begin
            check("req_held", 32'(bus.mem_req), 1);
            check("mem_addr", bus.mem_addr, eaddr);
            check("mem_wen",  32'(bus.mem_wen), 32'(ewen));
            check("mem_strb", 32'(bus.mem_strb), 32'(estrb));
            if (chk_wdata) check("mem_wdata", bus.mem_wdata, ewdata);
            if (poke_rx) check("rx_busy", 32'(bus.rx_ready), 0);
            if (i == dly) bus.mem_gnt = 1'b1;
            @(negedge clk);
        end
        bus.mem_gnt  = 1'b0;
        bus.rx_valid = 1'b0;
        check("req_drop", 32'(bus.mem_req), 0);
        check("ack_rise", 32'(bus.mem_ack), 1);
        bus.mem_recv  = 1'b1;
        bus.mem_rdata = rd;
        bus.mem_error = er;
        @(negedge clk);
        bus.mem_recv  = 1'b0;
        bus.mem_error = 1'b0;
        check("ack_drop", 32'(bus.mem_ack), 0);
        check("stat_latency", 32'(bus.tx_valid), 1);
        check("stat_byte", 32'(bus.tx_data), 32'(er));
    endtask

    // Collect n reply bytes; call at a negedge. Optionally toggle tx_ready.
    task automatic get_reply(input int n, input bit toggle);
        int got = 0;
        int cyc = 0;
        logic [7:0] held = 8'h00;
        bit stalled = 1'b0;
        while (got < n && cyc < 200) begin
            bus.tx_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (bus.tx_valid) begin
                if (stalled) check("tx_hold", 32'(bus.tx_data), 32'(held));
                if (bus.tx_ready) begin
                    rep[got] = bus.tx_data;
                    got++;
                    stalled = 1'b0;
                end else begin
                    held = bus.tx_data;
                    stalled = 1'b1;
                end
            end
            cyc++;
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;
        if (got < n) check("tx_timeout", 32'(got), 32'(n));
        check("tx_done", 32'(bus.tx_valid), 0);
        nrep = got;
    endtask

    task automatic check_reply(input string tag, input logic [7:0] e [5], input int n);
        check({tag, "_len"}, 32'(nrep), 32'(n));
        for (int i = 0; i < n && i < nrep; i++) check(tag, 32'(rep[i]), 32'(e[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_recv = 1'b0; bus.mem_error = 1'b0; bus.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outs();
        rst = 1'b0;
        check("rx_ready_pre_edge", 32'(bus.rx_ready), 0);
        @(negedge clk);
        check("rx_ready_rise", 32'(bus.rx_ready), 1);

        // WRITE 0xDEADBEEF to 0x10001010
        send_n('{8'h02, 8'h10, 8'h10, 8'h00, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 9);
        mem_serve(0, 32'h0, 1'b0, 32'h1000_1010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0);
        get_reply(1, 1'b0);
        check_reply("wr_reply", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

        // READ 0x10000000 -> 0x12345678
        send_n('{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        mem_serve(0, 32'h1234_5678, 1'b0, 32'h1000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        get_reply(5, 1'b0);
        check_reply("rd_reply", '{8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 5);

        // READ with responder error
        send_n('{8'h01, 8'h04, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        mem_serve(2, 32'hCAFE_F00D, 1'b1, 32'h2000_0004, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        get_reply(5, 1'b0);
        check_reply("err_reply", '{8'h01, 8'h0D, 8'hF0, 8'hFE, 8'hCA}, 5);

        // Bad opcode, then a normal READ
        send(8'h7F);
        @(negedge clk);
        check("bad_tx_valid", 32'(bus.tx_valid), 1);
        check("bad_no_req", 32'(bus.mem_req), 0);
        get_reply(1, 1'b0);
        check_reply("bad_reply", '{8'hEE, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
        check("bad_grants", 32'(grants), 3);
        send_n('{8'h01, 8'h08, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        mem_serve(0, 32'hA5A5_5A5A, 1'b0, 32'h1000_0008, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        get_reply(5, 1'b0);
        check_reply("post_bad", '{8'h00, 8'h5A, 8'h5A, 8'hA5, 8'hA5}, 5);

        // Stalled READ: unaligned host address, late grant, busy rx, toggling tx_ready
        send_n('{8'h01, 8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        mem_serve(5, 32'h0BAD_F00D, 1'b0, 32'h1000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
        get_reply(5, 1'b1);
        check_reply("stall_rd", '{8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B}, 5);

        // Stalled WRITE to 0x00000FFE -> word 0x00000FFC
        send_n('{8'h02, 8'hFE, 8'h0F, 8'h00, 8'h00, 8'h67, 8'h45, 8'h23, 8'h01}, 9);
        mem_serve(3, 32'h0, 1'b0, 32'h0000_0FFC, 1'b1, 4'hF, 32'h0123_4567, 1'b1, 1'b1);
        get_reply(1, 1'b1);
        check_reply("stall_wr", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);

        // Reset while a WRITE request is waiting for grant
        send_n('{8'h02, 8'h40, 8'h00, 8'h00, 8'h00, 8'h99, 8'h88, 8'h77, 8'h66}, 9);
        @(negedge clk);
        check("pre_rst_req", 32'(bus.mem_req), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.rx_ready), 1);
        check("post_rst_req", 32'(bus.mem_req), 0);
        send_n('{8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 9);
        mem_serve(1, 32'h0, 1'b0, 32'h0000_0020, 1'b1, 4'hF, 32'h4433_2211, 1'b1, 1'b0);
        get_reply(1, 1'b0);
        check_reply("post_rst_wr", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
        check("total_grants", 32'(grants), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
